// File: rtl/cdda_capture_pkg.sv
// Shared definitions for the serial audio capture block.
// Holds the FSM encoding, register map, status bit positions and frame width.
package cdda_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_LEFT,
        ST_RIGHT
    } cap_state_e;

    localparam logic [1:0] REG_STATUS  = 2'd0;
    localparam logic [1:0] REG_WRPOS   = 2'd1;
    localparam logic [1:0] REG_STOP    = 2'd2;
    localparam logic [1:0] REG_SCRATCH = 2'd3;

    localparam int STAT_EN    = 0;
    localparam int STAT_OVF   = 1;
    localparam int STAT_SHORT = 2;

    localparam int FRAME_BITS = 16;

endpackage

// File: rtl/cdda_capture_if.sv
// SRAM-style CPU bus window shared with the CDDA playback path.
// master = CPU side, slave = peripheral side.
interface cdda_capture_if;
    logic [10:0] sram_a;
    logic [7:0]  sram_d_in;
    logic [7:0]  sram_d_out;
    logic        sram_cs;
    logic        sram_oe;
    logic        sram_we;
    logic        sram_wait;

    modport master (
        output sram_a, sram_d_in, sram_cs, sram_oe, sram_we,
        input  sram_d_out, sram_wait
    );

    modport slave (
        input  sram_a, sram_d_in, sram_cs, sram_oe, sram_we,
        output sram_d_out, sram_wait
    );
endinterface

// File: rtl/capture_data_buffer.sv
// 256 x 16 simple dual-port sample RAM, one write port, registered read.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read, one-cycle latency).
module capture_data_buffer
    import cdda_capture_pkg::*;
(
    input  logic                  clk,
    input  logic                  we,
    input  logic [7:0]            waddr,
    input  logic [FRAME_BITS-1:0] wdata,
    input  logic [7:0]            raddr,
    output logic [FRAME_BITS-1:0] rdata
);
    logic [FRAME_BITS-1:0] mem_q [256];
    logic [FRAME_BITS-1:0] rdata_q;

    // Read-before-write: a same-cycle write to the read slot returns old data.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/cdda_capture.sv
// Serial stereo audio receiver: BCK/SD/LRCK in, 256-frame L/R buffers out.
// Ports: clk, rst (sync, active-high), bck/sd/lrck serial in, bus = CPU window.
module cdda_capture
    import cdda_capture_pkg::*;
#(
    parameter int CLK_FREQUENCY = 33868800
) (
    input  logic clk,
    input  logic rst,
    input  logic bck,
    input  logic sd,
    input  logic lrck,
    cdda_capture_if.slave bus
);
    // Synchronizer depth is fixed; the clock rate is carried for documentation.
    localparam int SYNC_DEPTH = 2 + 0 * CLK_FREQUENCY;

    logic [SYNC_DEPTH-1:0][2:0] sync_q, sync_d;
    logic bck_prev_q, lr_prev_q;
    logic [FRAME_BITS-1:0] shift_q, shift_d, hold_l_q, hold_l_d;
    logic [4:0] cnt_q, cnt_d;
    cap_state_e state_q, state_d;
    logic enabled_q, enabled_d, overflow_q, overflow_d, short_q, short_d;
    logic [7:0] wrpos_q, wrpos_d, stop_q, stop_d, scratch_q, scratch_d;
    logic rd_hit_q, rd_hit_d;
    logic [10:0] rd_addr_q;

    logic bck_s, sd_s, lr_s, bck_rise, lr_rise, lr_fall, full;
    logic hold_load, frame_done, short_hit, ram_we, ovf_hit;
    logic reg_wr, ovf_clr, short_clr, buf_rd;
    logic [1:0] reg_sel;
    logic [7:0] reg_rdata, buf_byte;
    logic [FRAME_BITS-1:0] rdata_l, rdata_r, rword;

    assign sync_d   = {sync_q[SYNC_DEPTH-2:0], {bck, sd, lrck}};
    assign bck_s    = sync_q[SYNC_DEPTH-1][2];
    assign sd_s     = sync_q[SYNC_DEPTH-1][1];
    assign lr_s     = sync_q[SYNC_DEPTH-1][0];
    assign bck_rise = bck_s & ~bck_prev_q;
    assign lr_rise  = lr_s & ~lr_prev_q;
    assign lr_fall  = ~lr_s & lr_prev_q;
    assign full     = (cnt_q == 5'(FRAME_BITS));

    always_comb begin
        shift_d = bck_rise ? {shift_q[FRAME_BITS-2:0], sd_s} : shift_q;
        cnt_d   = cnt_q;
        if (lr_rise || lr_fall)    cnt_d = '0;
        else if (bck_rise && !full) cnt_d = cnt_q + 5'd1;
        hold_l_d = hold_load ? shift_q : hold_l_q;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        if (!enabled_q) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:  state_d = ST_ALIGN;
                ST_ALIGN: if (lr_fall) state_d = ST_LEFT;
                ST_LEFT:  if (lr_rise) state_d = full ? ST_RIGHT : ST_ALIGN;
                ST_RIGHT: if (lr_fall) state_d = ST_LEFT;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        hold_load  = 1'b0;
        frame_done = 1'b0;
        short_hit  = 1'b0;
        if (enabled_q) begin
            unique case (state_q)
                ST_LEFT: if (lr_rise) begin
                    hold_load = full;
                    short_hit = !full;
                end
                ST_RIGHT: if (lr_fall) begin
                    frame_done = full;
                    short_hit  = !full;
                end
                default: ;
            endcase
        end
    end

    // stop is the first slot that may not be written.
    assign ovf_hit = frame_done && (wrpos_q == stop_q);
    assign ram_we  = frame_done && !overflow_q && (wrpos_q != stop_q);

    assign reg_sel   = bus.sram_a[1:0];
    assign reg_wr    = bus.sram_cs & bus.sram_we & ~bus.sram_a[10];
    assign ovf_clr   = reg_wr && reg_sel == REG_STATUS && bus.sram_d_in[STAT_OVF];
    assign short_clr = reg_wr && reg_sel == REG_STATUS && bus.sram_d_in[STAT_SHORT];

    always_comb begin
        enabled_d  = enabled_q;
        overflow_d = (overflow_q & ~ovf_clr) | ovf_hit;
        short_d    = (short_q & ~short_clr) | short_hit;
        wrpos_d    = ram_we ? wrpos_q + 8'd1 : wrpos_q;
        stop_d     = stop_q;
        scratch_d  = scratch_q;
        // A CPU write to wrpos overrides the commit increment.
        if (reg_wr) begin
            unique case (reg_sel)
                REG_STATUS:  enabled_d = bus.sram_d_in[STAT_EN];
                REG_WRPOS:   wrpos_d   = bus.sram_d_in;
                REG_STOP:    stop_d    = bus.sram_d_in;
                REG_SCRATCH: scratch_d = bus.sram_d_in;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            bck_prev_q <= 1'b0;
            lr_prev_q  <= 1'b0;
            shift_q    <= '0;
            cnt_q      <= '0;
            hold_l_q   <= '0;
            enabled_q  <= 1'b0;
            overflow_q <= 1'b0;
            short_q    <= 1'b0;
            wrpos_q    <= 8'h00;
            stop_q     <= 8'h00;
            scratch_q  <= 8'h55;
            rd_hit_q   <= 1'b0;
            rd_addr_q  <= '0;
        end else begin
            sync_q     <= sync_d;
            bck_prev_q <= bck_s;
            lr_prev_q  <= lr_s;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            hold_l_q   <= hold_l_d;
            enabled_q  <= enabled_d;
            overflow_q <= overflow_d;
            short_q    <= short_d;
            wrpos_q    <= wrpos_d;
            stop_q     <= stop_d;
            scratch_q  <= scratch_d;
            rd_hit_q   <= rd_hit_d;
            rd_addr_q  <= bus.sram_a;
        end
    end

    capture_data_buffer u_buf_l (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wrpos_q),
        .wdata (hold_l_q),
        .raddr (bus.sram_a[9:2]),
        .rdata (rdata_l)
    );

    capture_data_buffer u_buf_r (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wrpos_q),
        .wdata (shift_q),
        .raddr (bus.sram_a[9:2]),
        .rdata (rdata_r)
    );

    // Wait for one cycle whenever a buffer access starts or its address moves.
    assign buf_rd   = bus.sram_cs & bus.sram_oe & bus.sram_a[10];
    assign rd_hit_d = buf_rd;
    assign bus.sram_wait = buf_rd & ~(rd_hit_q && rd_addr_q == bus.sram_a);

    always_comb begin
        reg_rdata = 8'h00;
        unique case (reg_sel)
            REG_STATUS: begin
                reg_rdata[STAT_EN]    = enabled_q;
                reg_rdata[STAT_OVF]   = overflow_q;
                reg_rdata[STAT_SHORT] = short_q;
            end
            REG_WRPOS:   reg_rdata = wrpos_q;
            REG_STOP:    reg_rdata = stop_q;
            REG_SCRATCH: reg_rdata = scratch_q;
            default: ;
        endcase
    end

    assign rword    = bus.sram_a[1] ? rdata_r : rdata_l;
    assign buf_byte = bus.sram_a[0] ? rword[7:0] : rword[15:8];
    assign bus.sram_d_out = bus.sram_a[10] ? buf_byte : reg_rdata;

endmodule

// File: tb/tb_cdda_capture.sv
// Directed bench for cdda_capture: serial frame generator plus CPU bus tasks.
// Each scenario task checks its own expected values inline.
module tb_cdda_capture;

    logic clk = 1'b0;
    logic rst, bck, sd, lrck;
    int   n_tests = 0;
    int   n_fail  = 0;

    cdda_capture_if bus ();

    cdda_capture #(.CLK_FREQUENCY(33868800)) dut (
        .clk  (clk),
        .rst  (rst),
        .bck  (bck),
        .sd   (sd),
        .lrck (lrck),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic cpu_write(input logic [10:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.sram_a = a;
        bus.sram_d_in = d;
        bus.sram_cs = 1'b1;
        bus.sram_we = 1'b1;
        @(negedge clk);
        bus.sram_cs = 1'b0;
        bus.sram_we = 1'b0;
    endtask

    task automatic cpu_read(input logic [10:0] a, output logic [7:0] d, output int waits);
        @(negedge clk);
        bus.sram_a = a;
        bus.sram_cs = 1'b1;
        bus.sram_oe = 1'b1;
        #1;
        waits = 0;
        while (bus.sram_wait && waits < 4) begin
            @(negedge clk);
            #1;
            waits++;
        end
        d = bus.sram_d_out;
        @(negedge clk);
        bus.sram_cs = 1'b0;
        bus.sram_oe = 1'b0;
    endtask

    // Bits above 15 are junk ones that the receiver must discard.
    task automatic send_bits(input logic [15:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sd = (i < 16) ? w[i] : 1'b1;
            repeat (4) @(negedge clk);
            bck = 1'b1;
            repeat (4) @(negedge clk);
            bck = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                              input int nl, input int nr);
        lrck = 1'b0;
        send_bits(l, nl);
        lrck = 1'b1;
        send_bits(r, nr);
    endtask

    task automatic frame_close();
        lrck = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] v;
        int w;
        logic [7:0] exp_r [4];
        exp_r = '{8'h00, 8'h00, 8'h00, 8'h55};
        rst = 1'b1;
        bck = 1'b0; sd = 1'b0; lrck = 1'b0;
        bus.sram_a = '0; bus.sram_d_in = '0;
        bus.sram_cs = 1'b0; bus.sram_oe = 1'b0; bus.sram_we = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.sram_d_out !== 8'h00 || bus.sram_wait !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out got d=%h wait=%b want d=00 wait=0",
                     bus.sram_d_out, bus.sram_wait);
        end
        for (int i = 0; i < 4; i++) begin
            cpu_read(11'(i), v, w);
            n_tests++;
            if (v !== exp_r[i]) begin
                n_fail++;
                $display("FAIL reset_reg%0d got %h want %h", i, v, exp_r[i]);
            end
            n_tests++;
            if (w !== 0) begin
                n_fail++;
                $display("FAIL reset_wait%0d got %0d want 0", i, w);
            end
        end
    endtask

    task automatic test_capture();
        logic [7:0] v;
        int w;
        logic [10:0] adr [5];
        logic [7:0]  exp_b [5];
        adr   = '{11'h400, 11'h401, 11'h402, 11'h403, 11'h407};
        exp_b = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'hFF};
        cpu_write(11'h002, 8'h10);
        lrck = 1'b1;
        repeat (8) @(negedge clk);
        cpu_write(11'h000, 8'h01);
        repeat (4) @(negedge clk);
        send_frame(16'h1234, 16'hABCD, 16, 16);
        send_frame(16'h0001, 16'hFFFF, 16, 16);
        frame_close();
        cpu_read(11'h001, v, w);
        n_tests++;
        if (v !== 8'h02) begin
            n_fail++;
            $display("FAIL cap_wrpos got %h want 02", v);
        end
        for (int i = 0; i < 5; i++) begin
            cpu_read(adr[i], v, w);
            n_tests++;
            if (v !== exp_b[i]) begin
                n_fail++;
                $display("FAIL cap_buf_%h got %h want %h", adr[i], v, exp_b[i]);
            end
            n_tests++;
            if (w !== 1) begin
                n_fail++;
                $display("FAIL cap_wait_%h got %0d want 1", adr[i], w);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] v;
        int w;
        logic [10:0] adr [4];
        logic [7:0]  exp_b [4];
        adr   = '{11'h7F8, 11'h7FF, 11'h401, 11'h405};
        exp_b = '{8'hA0, 8'hB3, 8'hA5, 8'h01};
        cpu_write(11'h001, 8'hFE);
        cpu_write(11'h002, 8'h01);
        send_frame(16'hA0A1, 16'hB0B1, 20, 20);
        send_frame(16'hA2A3, 16'hB2B3, 20, 20);
        send_frame(16'hA4A5, 16'hB4B5, 20, 20);
        send_frame(16'hA6A7, 16'hB6B7, 20, 20);
        frame_close();
        cpu_read(11'h001, v, w);
        n_tests++;
        if (v !== 8'h01) begin
            n_fail++;
            $display("FAIL ovf_wrpos got %h want 01", v);
        end
        cpu_read(11'h000, v, w);
        n_tests++;
        if (v !== 8'h03) begin
            n_fail++;
            $display("FAIL ovf_status got %h want 03", v);
        end
        for (int i = 0; i < 4; i++) begin
            cpu_read(adr[i], v, w);
            n_tests++;
            if (v !== exp_b[i]) begin
                n_fail++;
                $display("FAIL ovf_buf_%h got %h want %h", adr[i], v, exp_b[i]);
            end
        end
        cpu_write(11'h000, 8'h03);
        cpu_read(11'h000, v, w);
        n_tests++;
        if (v !== 8'h01) begin
            n_fail++;
            $display("FAIL ovf_clear got %h want 01", v);
        end
    endtask

    task automatic test_align_disable();
        logic [7:0] v;
        int w;
        cpu_write(11'h000, 8'h00);
        cpu_write(11'h002, 8'h80);
        cpu_write(11'h001, 8'h20);
        lrck = 1'b1;
        send_bits(16'h0F0F, 16);
        lrck = 1'b0;
        send_bits(16'h00AB, 8);
        cpu_write(11'h000, 8'h01);
        send_bits(16'h00CD, 8);
        lrck = 1'b1;
        send_bits(16'h3333, 16);
        cpu_read(11'h001, v, w);
        n_tests++;
        if (v !== 8'h20) begin
            n_fail++;
            $display("FAIL align_partial got %h want 20", v);
        end
        send_frame(16'h5A5A, 16'hC3C3, 16, 16);
        frame_close();
        cpu_read(11'h001, v, w);
        n_tests++;
        if (v !== 8'h21) begin
            n_fail++;
            $display("FAIL align_wrpos got %h want 21", v);
        end
        cpu_read(11'h480, v, w);
        n_tests++;
        if (v !== 8'h5A) begin
            n_fail++;
            $display("FAIL align_buf_l got %h want 5a", v);
        end
        cpu_read(11'h483, v, w);
        n_tests++;
        if (v !== 8'hC3) begin
            n_fail++;
            $display("FAIL align_buf_r got %h want c3", v);
        end
        send_bits(16'h1111, 16);
        lrck = 1'b1;
        send_bits(16'h2222, 8);
        cpu_write(11'h000, 8'h00);
        send_bits(16'h2222, 8);
        frame_close();
        cpu_read(11'h001, v, w);
        n_tests++;
        if (v !== 8'h21) begin
            n_fail++;
            $display("FAIL disable_wrpos got %h want 21", v);
        end
        cpu_read(11'h000, v, w);
        n_tests++;
        if (v !== 8'h00) begin
            n_fail++;
            $display("FAIL disable_status got %h want 00", v);
        end
    endtask

    task automatic test_short();
        logic [7:0] v;
        int w;
        cpu_write(11'h000, 8'h01);
        lrck = 1'b1;
        repeat (8) @(negedge clk);
        send_frame(16'h7777, 16'h8888, 16, 12);
        frame_close();
        cpu_read(11'h000, v, w);
        n_tests++;
        if (v !== 8'h05) begin
            n_fail++;
            $display("FAIL short_status got %h want 05", v);
        end
        cpu_read(11'h001, v, w);
        n_tests++;
        if (v !== 8'h21) begin
            n_fail++;
            $display("FAIL short_wrpos got %h want 21", v);
        end
        send_frame(16'h1357, 16'h2468, 16, 16);
        frame_close();
        cpu_read(11'h001, v, w);
        n_tests++;
        if (v !== 8'h22) begin
            n_fail++;
            $display("FAIL short_next_wrpos got %h want 22", v);
        end
        cpu_read(11'h486, v, w);
        n_tests++;
        if (v !== 8'h24) begin
            n_fail++;
            $display("FAIL short_next_buf got %h want 24", v);
        end
        cpu_write(11'h000, 8'h05);
        cpu_read(11'h000, v, w);
        n_tests++;
        if (v !== 8'h01) begin
            n_fail++;
            $display("FAIL short_clear got %h want 01", v);
        end
    endtask

    task automatic test_collision();
        logic [7:0] v;
        int w;
        cpu_write(11'h001, 8'h05);
        send_frame(16'h9ABC, 16'hDEF0, 16, 16);
        lrck = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.sram_a = 11'h001;
        bus.sram_d_in = 8'h40;
        bus.sram_cs = 1'b1;
        bus.sram_we = 1'b1;
        @(negedge clk);
        bus.sram_cs = 1'b0;
        bus.sram_we = 1'b0;
        repeat (4) @(negedge clk);
        cpu_read(11'h001, v, w);
        n_tests++;
        if (v !== 8'h40) begin
            n_fail++;
            $display("FAIL coll_wrpos got %h want 40", v);
        end
        cpu_read(11'h414, v, w);
        n_tests++;
        if (v !== 8'h9A) begin
            n_fail++;
            $display("FAIL coll_buf_l got %h want 9a", v);
        end
        cpu_read(11'h417, v, w);
        n_tests++;
        if (v !== 8'hF0) begin
            n_fail++;
            $display("FAIL coll_buf_r got %h want f0", v);
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_overflow();
        test_align_disable();
        test_short();
        test_collision();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
